// File: rtl/ysyx_22050019_axi_rd_arb_pkg.sv
// Shared AXI read-arbiter definitions: FSM encodings, RRESP codes and owner encodings.
package ysyx_22050019_axi_rd_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2
    } arb_state_e;

    localparam logic [1:0] RRESP_OKAY   = 2'b00;
    localparam logic [1:0] RRESP_EXOKAY = 2'b01;
    localparam logic [1:0] RRESP_SLVERR = 2'b10;
    localparam logic [1:0] RRESP_DECERR = 2'b11;

    // One-hot owner: bit0 IFU (m0), bit1 LSU (m1).
    localparam logic [1:0] OWNER_NONE = 2'b00;
    localparam logic [1:0] OWNER_IFU  = 2'b01;
    localparam logic [1:0] OWNER_LSU  = 2'b10;

endpackage

// File: rtl/ysyx_22050019_rr_arb2.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the one not granted last.
module ysyx_22050019_rr_arb2
    import ysyx_22050019_axi_rd_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic [1:0] last_grant,
    output logic [1:0] grant
);

    always_comb begin
        grant = req;
        if (req == 2'b11) begin
            grant = last_grant[0] ? OWNER_LSU : OWNER_IFU;
        end
    end

endmodule

// File: rtl/ysyx_22050019_axi_rd_arb.sv
// Arbitrates IFU (m0) and LSU (m1) AXI read requests onto one slave, one single-beat read at a time.
module ysyx_22050019_axi_rd_arb
    import ysyx_22050019_axi_rd_arb_pkg::*;
#(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,

    input  logic              m0_arvalid,
    input  logic [ADDR_W-1:0] m0_araddr,
    output logic              m0_arready,
    output logic              m0_rvalid,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_rresp,
    input  logic              m0_rready,

    input  logic              m1_arvalid,
    input  logic [ADDR_W-1:0] m1_araddr,
    output logic              m1_arready,
    output logic              m1_rvalid,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_rresp,
    input  logic              m1_rready,

    output logic              s_arvalid,
    output logic [ADDR_W-1:0] s_araddr,
    input  logic              s_arready,
    input  logic              s_rvalid,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_rresp,
    output logic              s_rready,

    output logic [1:0]        grant_o,
    output logic              busy_o
);

    arb_state_e        state_q;
    arb_state_e        state_d;
    logic [ADDR_W-1:0] addr_p1;
    logic [1:0]        owner_p1;
    logic [1:0]        last_grant_q;
    logic [1:0]        pick;
    logic              accept;
    logic              owner_rready;
    logic              r_done;

    ysyx_22050019_rr_arb2 u_rr_arb2 (
        .req        ({m1_arvalid, m0_arvalid}),
        .last_grant (last_grant_q),
        .grant      (pick)
    );

    assign accept       = (state_q == ST_IDLE) && (pick != OWNER_NONE);
    assign owner_rready = (owner_p1[0] & m0_rready) | (owner_p1[1] & m1_rready);
    assign r_done       = (state_q == ST_DATA) && s_rvalid && owner_rready;
    assign s_araddr     = addr_p1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Accept stage: capture the winner's address and ownership for the whole transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_p1      <= '0;
            owner_p1     <= OWNER_NONE;
            last_grant_q <= OWNER_IFU;
        end else if (accept) begin
            addr_p1      <= pick[1] ? m1_araddr : m0_araddr;
            owner_p1     <= pick;
            last_grant_q <= pick;
        end else if (r_done) begin
            owner_p1     <= OWNER_NONE;
        end
    end

    always_comb begin
        state_d    = state_q;
        m0_arready = 1'b0;
        m1_arready = 1'b0;
        m0_rvalid  = 1'b0;
        m1_rvalid  = 1'b0;
        m0_rdata   = '0;
        m1_rdata   = '0;
        m0_rresp   = 2'b00;
        m1_rresp   = 2'b00;
        s_arvalid  = 1'b0;
        s_rready   = 1'b0;
        grant_o    = OWNER_NONE;
        busy_o     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                // Gated by rst_n so a master holding arvalid sees no arready while in reset.
                m0_arready = pick[0] & rst_n;
                m1_arready = pick[1] & rst_n;
                if (accept) begin
                    state_d = ST_ADDR;
                end
            end
            ST_ADDR: begin
                s_arvalid = 1'b1;
                grant_o   = owner_p1;
                busy_o    = 1'b1;
                if (s_arready) begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                grant_o   = owner_p1;
                busy_o    = 1'b1;
                s_rready  = owner_rready;
                m0_rvalid = owner_p1[0] & s_rvalid;
                m1_rvalid = owner_p1[1] & s_rvalid;
                if (owner_p1[0]) begin
                    m0_rdata = s_rdata;
                    m0_rresp = s_rresp;
                end
                if (owner_p1[1]) begin
                    m1_rdata = s_rdata;
                    m1_rresp = s_rresp;
                end
                if (r_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_ysyx_22050019_axi_rd_arb.sv
// Directed bench: stimulus pushes expected AR/R beats into queues, monitors pop and compare on handshakes.
module tb_ysyx_22050019_axi_rd_arb;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        m0_arvalid = 1'b0;
    logic [63:0] m0_araddr = '0;
    logic        m0_arready;
    logic        m0_rvalid;
    logic [63:0] m0_rdata;
    logic [1:0]  m0_rresp;
    logic        m0_rready = 1'b1;
    logic        m1_arvalid = 1'b0;
    logic [63:0] m1_araddr = '0;
    logic        m1_arready;
    logic        m1_rvalid;
    logic [63:0] m1_rdata;
    logic [1:0]  m1_rresp;
    logic        m1_rready = 1'b1;
    logic        s_arvalid;
    logic [63:0] s_araddr;
    logic        s_arready = 1'b0;
    logic        s_rvalid = 1'b0;
    logic [63:0] s_rdata = '0;
    logic [1:0]  s_rresp = 2'b00;
    logic        s_rready;
    logic [1:0]  grant_o;
    logic        busy_o;

    typedef struct { logic [1:0] own; logic [63:0] addr; } ar_t;
    typedef struct { logic [1:0] own; logic [63:0] data; logic [1:0] resp; } r_t;
    ar_t exp_ar[$];
    r_t  exp_r[$];

    int n_chk = 0;
    int n_fail = 0;

    ysyx_22050019_axi_rd_arb #(.ADDR_W(64), .DATA_W(64)) dut (
        .clk(clk), .rst_n(rst_n),
        .m0_arvalid(m0_arvalid), .m0_araddr(m0_araddr), .m0_arready(m0_arready),
        .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp), .m0_rready(m0_rready),
        .m1_arvalid(m1_arvalid), .m1_araddr(m1_araddr), .m1_arready(m1_arready),
        .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp), .m1_rready(m1_rready),
        .s_arvalid(s_arvalid), .s_araddr(s_araddr), .s_arready(s_arready),
        .s_rvalid(s_rvalid), .s_rdata(s_rdata), .s_rresp(s_rresp), .s_rready(s_rready),
        .grant_o(grant_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_m0_arready"}, 64'(m0_arready), 64'd0);
        chk({tag, "_m1_arready"}, 64'(m1_arready), 64'd0);
        chk({tag, "_m0_rvalid"},  64'(m0_rvalid),  64'd0);
        chk({tag, "_m1_rvalid"},  64'(m1_rvalid),  64'd0);
        chk({tag, "_s_arvalid"},  64'(s_arvalid),  64'd0);
        chk({tag, "_s_rready"},   64'(s_rready),   64'd0);
        chk({tag, "_grant"},      64'(grant_o),    64'd0);
        chk({tag, "_busy"},       64'(busy_o),     64'd0);
        chk({tag, "_m0_rdata"},   m0_rdata,        64'd0);
        chk({tag, "_m1_rdata"},   m1_rdata,        64'd0);
        chk({tag, "_m0_rresp"},   64'(m0_rresp),   64'd0);
        chk({tag, "_m1_rresp"},   64'(m1_rresp),   64'd0);
        chk({tag, "_s_araddr"},   s_araddr,        64'd0);
    endtask

    // Present requests in IDLE, check the combinational grant, let the edge accept it.
    task automatic req(input logic v0, input logic [63:0] a0, input logic v1, input logic [63:0] a1,
                       input logic [1:0] exp_gnt);
        m0_arvalid = v0; m0_araddr = a0;
        m1_arvalid = v1; m1_araddr = a1;
        #1;
        chk("idle_arready", 64'({m1_arready, m0_arready}), 64'(exp_gnt));
        chk("idle_busy", 64'(busy_o), 64'd0);
        chk("idle_grant", 64'(grant_o), 64'd0);
        tick();
        if (exp_gnt[0]) m0_arvalid = 1'b0;
        if (exp_gnt[1]) m1_arvalid = 1'b0;
    endtask

    // Act as the slave for one accepted transaction, starting in ADDR.
    task automatic serve(input logic [1:0] own, input logic [63:0] addr, input logic [63:0] data,
                         input logic [1:0] resp, input int ar_wait, input int r_stall);
        exp_ar.push_back('{own, addr});
        exp_r.push_back('{own, data, resp});
        for (int i = 0; i < ar_wait; i++) begin
            s_arready = 1'b0;
            #1;
            chk("ar_wait_valid", 64'(s_arvalid), 64'd1);
            chk("ar_wait_addr", s_araddr, addr);
            chk("ar_wait_grant", 64'(grant_o), 64'(own));
            chk("ar_wait_arready", 64'({m1_arready, m0_arready}), 64'd0);
            tick();
        end
        s_arready = 1'b1;
        #1;
        chk("addr_valid", 64'(s_arvalid), 64'd1);
        chk("addr_busy", 64'(busy_o), 64'd1);
        chk("addr_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'd0);
        tick();
        s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = data; s_rresp = resp;
        for (int i = 0; i < r_stall; i++) begin
            if (own[0]) m0_rready = 1'b0; else m1_rready = 1'b0;
            #1;
            chk("stall_busy", 64'(busy_o), 64'd1);
            chk("stall_s_rready", 64'(s_rready), 64'd0);
            chk("stall_rvalid", 64'(own[0] ? m0_rvalid : m1_rvalid), 64'd1);
            tick();
        end
        m0_rready = 1'b1; m1_rready = 1'b1;
        #1;
        chk("data_s_rready", 64'(s_rready), 64'd1);
        chk("data_other_rvalid", 64'(own[0] ? m1_rvalid : m0_rvalid), 64'd0);
        chk("data_no_accept", 64'({m1_arready, m0_arready}), 64'd0);
        tick();
        s_rvalid = 1'b0; s_rdata = '0; s_rresp = 2'b00;
        #1;
        chk("done_busy", 64'(busy_o), 64'd0);
    endtask

    // Scoreboard monitors: slave address handshakes and master response handshakes.
    always @(negedge clk) begin : mon
        ar_t ea;
        r_t  er;
        logic h0, h1;
        if (s_arvalid && s_arready) begin
            if (exp_ar.size() == 0) begin
                chk("ar_unexpected", s_araddr, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                ea = exp_ar.pop_front();
                chk("ar_addr", s_araddr, ea.addr);
                chk("ar_owner", 64'(grant_o), 64'(ea.own));
            end
        end
        h0 = m0_rvalid && m0_rready;
        h1 = m1_rvalid && m1_rready;
        if (h0 && h1) begin
            chk("r_both_masters", 64'({h1, h0}), 64'd0);
        end else if (h0 || h1) begin
            if (exp_r.size() == 0) begin
                chk("r_unexpected", 64'({h1, h0}), 64'd0);
            end else begin
                er = exp_r.pop_front();
                chk("r_owner", 64'({h1, h0}), 64'(er.own));
                chk("r_data", h0 ? m0_rdata : m1_rdata, er.data);
                chk("r_resp", 64'(h0 ? m0_rresp : m1_rresp), 64'(er.resp));
            end
        end
    end

    initial begin
        m0_arvalid = 1'b1; m1_arvalid = 1'b1; s_rvalid = 1'b1; s_rdata = 64'h55AA;
        #1 rst_n = 1'b0;
        #2 chk_all_zero("reset");
        m0_arvalid = 1'b0; m1_arvalid = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        tick(); tick();
        rst_n = 1'b1;
        tick();

        // First contention after reset goes to LSU, then the waiting IFU.
        req(1'b1, 64'h8000_2000, 1'b1, 64'h8000_1000, 2'b10);
        serve(2'b10, 64'h8000_1000, 64'h1111_2222_3333_4444, 2'b00, 0, 0);
        req(1'b1, 64'h8000_2000, 1'b1, 64'h8000_1008, 2'b01);
        serve(2'b01, 64'h8000_2000, 64'hAAAA_BBBB_CCCC_DDDD, 2'b00, 0, 0);
        req(1'b0, 64'h0, 1'b1, 64'h8000_1008, 2'b10);
        serve(2'b10, 64'h8000_1008, 64'h0BAD_0BAD_0BAD_0BAD, 2'b10, 0, 0);
        req(1'b1, 64'h8000_0000, 1'b0, 64'h0, 2'b01);
        serve(2'b01, 64'h8000_0000, 64'h0000_0013_0000_0093, 2'b00, 0, 0);

        // Slave stalls arready while LSU waits for the bus.
        req(1'b1, 64'h8000_3000, 1'b0, 64'h0, 2'b01);
        m1_arvalid = 1'b1; m1_araddr = 64'h8000_1010;
        serve(2'b01, 64'h8000_3000, 64'h0123_4567_89AB_CDEF, 2'b01, 3, 0);
        req(1'b0, 64'h0, 1'b1, 64'h8000_1010, 2'b10);
        serve(2'b10, 64'h8000_1010, 64'hFEDC_BA98_7654_3210, 2'b11, 0, 0);

        // Lone requester wins even though it was granted last; then an IFU rready stall.
        req(1'b0, 64'h0, 1'b1, 64'h8000_1018, 2'b10);
        serve(2'b10, 64'h8000_1018, 64'h0000_0000_0000_0001, 2'b00, 0, 0);
        req(1'b1, 64'h8000_4000, 1'b0, 64'h0, 2'b01);
        serve(2'b01, 64'h8000_4000, 64'hCAFE_F00D_DEAD_BEEF, 2'b00, 0, 5);

        // Reset in the middle of DATA with the slave still presenting a response.
        req(1'b1, 64'h8000_5000, 1'b0, 64'h0, 2'b01);
        exp_ar.push_back('{2'b01, 64'h8000_5000});
        s_arready = 1'b1;
        #1;
        tick();
        s_arready = 1'b0;
        s_rvalid = 1'b1; s_rdata = 64'hDEAD_DEAD_DEAD_DEAD; s_rresp = 2'b00;
        m0_arvalid = 1'b1; m0_araddr = 64'h8000_6000;
        #1;
        chk("pre_reset_rvalid", 64'(m0_rvalid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("mid_reset");
        m0_arvalid = 1'b0;
        tick(); tick();
        rst_n = 1'b1;
        #1;
        chk("post_reset_busy", 64'(busy_o), 64'd0);
        chk("post_reset_rvalid", 64'({m1_rvalid, m0_rvalid}), 64'd0);
        tick();
        chk("post_reset_rvalid2", 64'({m1_rvalid, m0_rvalid}), 64'd0);
        s_rvalid = 1'b0; s_rdata = '0;
        tick();

        // last_grant is back to IFU, so a tie goes to LSU again.
        req(1'b1, 64'h8000_7000, 1'b1, 64'h8000_1020, 2'b10);
        serve(2'b10, 64'h8000_1020, 64'h7777_0000_0000_7777, 2'b00, 0, 0);
        req(1'b1, 64'h8000_7000, 1'b0, 64'h0, 2'b01);
        serve(2'b01, 64'h8000_7000, 64'h0000_8888_8888_0000, 2'b00, 0, 0);

        tick(); tick();
        chk("ar_queue_empty", 64'(exp_ar.size()), 64'd0);
        chk("r_queue_empty", 64'(exp_r.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/ysyx_22050019_axi_rd_arb.md
YSYX_22050019_AXI_RD_ARB -- requirements
Module: ysyx_22050019_axi_rd_arb

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, address width of all AR channels.
REQ-002 SHALL have parameter DATA_W, default 64, data width of all R channels.
REQ-003 SHALL have clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have m0_arvalid/m0_araddr  input  1/ADDR_W  IFU read request; m0_arready  output  1.
REQ-006 SHALL have m0_rvalid/m0_rdata/m0_rresp  output  1/DATA_W/2  IFU read response; m0_rready  input  1.
REQ-007 SHALL have m1_arvalid/m1_araddr  input  1/ADDR_W  LSU read request; m1_arready  output  1.
REQ-008 SHALL have m1_rvalid/m1_rdata/m1_rresp  output  1/DATA_W/2  LSU read response; m1_rready  input  1.
REQ-009 SHALL have s_arvalid/s_araddr  output  1/ADDR_W  shared slave read address; s_arready  input  1.
REQ-010 SHALL have s_rvalid/s_rdata/s_rresp  input  1/DATA_W/2  slave response; s_rready  output  1.
REQ-011 SHALL have grant_o  output  2  one-hot owner (bit0 IFU, bit1 LSU), 0 when idle; busy_o  output  1  transaction in flight.

Function
REQ-012 SHALL implement FSM states IDLE, ADDR, DATA; one outstanding single-beat read at a time.
REQ-013 In IDLE, with any mX_arvalid high, SHALL pick a winner combinationally and assert that master's mX_arready in the same cycle; loser's arready stays 0.
REQ-014 On accept, SHALL register the winner's araddr and owner, and move to ADDR next cycle.
REQ-015 Arbitration SHALL be round-robin: on both requesting, grant the master not granted last; last_grant resets to IFU, so first contention goes to LSU.
REQ-016 A single requester SHALL be granted immediately regardless of last_grant.
REQ-017 In ADDR, s_arvalid SHALL be 1 with the registered address held stable until s_arvalid&s_arready, then go to DATA.
REQ-018 In DATA, SHALL route s_rvalid/s_rdata/s_rresp to the owner only; s_rready SHALL equal owner's mX_rready; non-owner rvalid SHALL be 0.
REQ-019 On s_rvalid&s_rready in DATA, SHALL return to IDLE; a new request SHALL be accepted in the following cycle, never the same cycle.
REQ-020 Owner dropping rready (pipeline stall) SHALL hold DATA indefinitely with no response lost or duplicated.
REQ-021 s_rresp SHALL pass unmodified; SLVERR/DECERR SHALL NOT alter arbitration or state flow.
REQ-022 mX_arready SHALL be 0 outside IDLE; requests arriving in ADDR/DATA SHALL wait.
REQ-023 Minimum latency: accept at cycle N, s_arvalid at N+1, earliest response to master at N+2.
REQ-024 grant_o SHALL be the registered owner in ADDR/DATA; busy_o = (state != IDLE).

Reset
REQ-025 rst_n low SHALL force IDLE, last_grant=IFU, registered address 0, owner none, immediately and asynchronously.
REQ-026 During reset all outputs SHALL be 0: all arready/rvalid, s_arvalid, s_rready, grant_o, busy_o, rdata, rresp.
REQ-027 Reset mid-transaction SHALL abandon it; no response to any master is produced after release until a new accept.

Structure
REQ-028 FSM state encodings and AXI RRESP codes (OKAY 00, EXOKAY 01, SLVERR 10, DECERR 11) SHALL live in the shared AXI package/include.
REQ-029 The 2-way round-robin pick SHALL be one sub-module, ysyx_22050019_rr_arb2 (req[1:0], last_grant -> one-hot grant), purely combinational.

Verification
REQ-030 Only m0 requests 0x8000_0000 -> m0_arready same cycle, s_araddr=0x8000_0000 next cycle; s_rdata 0x00000013_00000093, OKAY -> delivered to m0 only.
REQ-031 m0 and m1 request together after reset (m1 addr 0x8000_1000) -> m1 served first, then m0; on next tie m1 is served last.
REQ-032 m0 drops rready 5 cycles while s_rvalid=1 -> state stays DATA, s_rready=0; exactly one handshake when rready returns.
REQ-033 Slave holds s_arready=0 for 3 cycles -> s_arvalid and s_araddr stable those cycles; m1 request meanwhile sees m1_arready=0.
REQ-034 rst_n low in DATA with s_rvalid=1 -> all outputs 0 asynchronously, IDLE after release, no stale rvalid.
REQ-035 Slave returns rresp=SLVERR for m1 -> m1_rresp=2'b10, then m0 request accepted normally.
